// File: rtl/buffer_ram_mp_if.sv
// ---------------------------------------------------------------------------
// buffer_ram_mp_if
// Read/write bus of the multi-lane buffer RAM.
//   rden   : read request for rows raddr .. raddr+LANES-1
//   raddr  : read base row
//   rdata  : read response, lane k in [k*WIDTH*WORDS +: WIDTH*WORDS]
//   rvalid : rdata carries a fresh read response this cycle
//   wren   : per-lane write enable
//   waddr  : write base row
//   wdata  : write data, lane-sliced like rdata
//   wmask  : bit [k*WORDS+j] enables word j of lane k
// master = requester (loader / operand fetch), slave = the RAM.
// ---------------------------------------------------------------------------
interface buffer_ram_mp_if #(
    parameter int DEPTHAD = 9,
    parameter int LANES   = 2,
    parameter int WIDTH   = 16,
    parameter int WORDS   = 32
);
    logic                         rden;
    logic [DEPTHAD-1:0]           raddr;
    logic [LANES*WIDTH*WORDS-1:0] rdata;
    logic                         rvalid;
    logic [LANES-1:0]             wren;
    logic [DEPTHAD-1:0]           waddr;
    logic [LANES*WIDTH*WORDS-1:0] wdata;
    logic [LANES*WORDS-1:0]       wmask;

    modport master (
        output rden, raddr, wren, waddr, wdata, wmask,
        input  rdata, rvalid
    );

    modport slave (
        input  rden, raddr, wren, waddr, wdata, wmask,
        output rdata, rvalid
    );
endinterface

// File: rtl/buffer_ram_mp.sv
// ---------------------------------------------------------------------------
// buffer_ram_mp
// Multi-lane on-chip buffer RAM for the feature/weight buffers. Every cycle
// LANES consecutive rows (wrapping modulo DEPTH) can be read and LANES
// consecutive rows written, with per-word write masks.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (clears read pipeline and outputs,
//         memory contents are kept; rden/wren ignored while high)
//   bus : buffer_ram_mp_if slave port (see interface header)
// Read latency: rden sampled at edge t -> rvalid/rdata after edge
// t+READ_LATENCY. RDW_MODE selects old (0) or merged new (1) data when a
// read row matches a write row in the same cycle.
// ---------------------------------------------------------------------------
`ifndef FSIZE
`define FSIZE 16
`endif
`ifndef BUFFER_READ_LATENCY
`define BUFFER_READ_LATENCY 2
`endif

module buffer_ram_mp #(
    parameter int ID           = 0,
    parameter int DEPTH        = 512,
    parameter int WIDTH        = `FSIZE,
    parameter int WORDS        = 32,
    parameter int LANES        = 2,
    parameter int READ_LATENCY = `BUFFER_READ_LATENCY,
    parameter int RDW_MODE     = 0,
    parameter int DEPTHAD      = $clog2(DEPTH)
) (
    input logic            clk,
    input logic            rst,
    buffer_ram_mp_if.slave bus
);
    localparam int ROWW  = WIDTH * WORDS;
    localparam int DATAW = LANES * ROWW;

    logic [ROWW-1:0] mem [DEPTH];

    logic [DEPTHAD-1:0] rrow [LANES];
    logic [DEPTHAD-1:0] wrow [LANES];

    logic [DATAW-1:0] rd_sample;

    logic             vld_reg [READ_LATENCY];
    logic [DATAW-1:0] dat_reg [READ_LATENCY];
    logic             rvalid_reg;
    logic [DATAW-1:0] rdata_reg;

    // Row of lane k. base < DEPTH and k < DEPTH, so one conditional
    // subtract is enough and non-power-of-two depths wrap correctly.
    function automatic logic [DEPTHAD-1:0] lane_row(input logic [DEPTHAD-1:0] base,
                                                    input int k);
        logic [DEPTHAD:0] sum;
        sum = {1'b0, base} + (DEPTHAD+1)'(k);
        if (sum >= (DEPTHAD+1)'(DEPTH))
            sum = sum - (DEPTHAD+1)'(DEPTH);
        return sum[DEPTHAD-1:0];
    endfunction

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_addr
        assign rrow[gi] = lane_row(bus.raddr, gi);
        assign wrow[gi] = lane_row(bus.waddr, gi);
    end

    // Read sample for stage 0. Memory is read before this edge's writes
    // land, which gives old data; in merge mode the masked words of any
    // lane writing the same row are substituted.
    always_comb begin
        logic [ROWW-1:0] row;
        rd_sample = '0;
        for (int a = 0; a < LANES; a++) begin
            row = mem[rrow[a]];
            if (RDW_MODE == 1) begin
                for (int b = 0; b < LANES; b++) begin
                    if (bus.wren[b] && (wrow[b] == rrow[a])) begin
                        for (int j = 0; j < WORDS; j++) begin
                            if (bus.wmask[b*WORDS + j])
                                row[j*WIDTH +: WIDTH] = bus.wdata[b*ROWW + j*WIDTH +: WIDTH];
                        end
                    end
                end
            end
            rd_sample[a*ROWW +: ROWW] = row;
        end
    end

    // Masked write port; lane rows are always distinct so lanes never collide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < LANES; k++) begin
                for (int j = 0; j < WORDS; j++) begin
                    if (bus.wren[k] && bus.wmask[k*WORDS + j])
                        mem[wrow[k]][j*WIDTH +: WIDTH] <= bus.wdata[k*ROWW + j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Read pipeline: READ_LATENCY stages followed by the output register.
    // Stage 0 and the output register only load on a valid beat, so the
    // last delivered data is held between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++)
                vld_reg[i] <= 1'b0;
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            vld_reg[0] <= bus.rden;
            if (bus.rden)
                dat_reg[0] <= rd_sample;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_reg[i] <= vld_reg[i-1];
                dat_reg[i] <= dat_reg[i-1];
            end
            rvalid_reg <= vld_reg[READ_LATENCY-1];
            if (vld_reg[READ_LATENCY-1])
                rdata_reg <= dat_reg[READ_LATENCY-1];
        end
    end

    assign bus.rvalid = rvalid_reg;
    assign bus.rdata  = rdata_reg;

    // Base addresses at or beyond DEPTH are illegal.
    always_ff @(posedge clk) begin
        if (!rst && bus.rden)
            assert ({1'b0, bus.raddr} < (DEPTHAD+1)'(DEPTH))
                else $error("buffer_ram_mp %0d: read base %0d out of range", ID, bus.raddr);
        if (!rst && (|bus.wren))
            assert ({1'b0, bus.waddr} < (DEPTHAD+1)'(DEPTH))
                else $error("buffer_ram_mp %0d: write base %0d out of range", ID, bus.waddr);
    end
endmodule

// File: tb/tb_buffer_ram_mp.sv
// ---------------------------------------------------------------------------
// tb_buffer_ram_mp
// Two instances share one stimulus stream:
//   dut_a : DEPTH 12, READ_LATENCY 1, RDW_MODE 0 (old data)
//   dut_b : DEPTH  6, READ_LATENCY 3, RDW_MODE 1 (merged data)
// Base addresses are reduced modulo each instance's depth. A reference
// memory per instance produces expected read data, pushed to a scoreboard
// with its due cycle and popped when the response is due.
// ---------------------------------------------------------------------------
module tb_buffer_ram_mp;
    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int LANES = 2;
    localparam int ROWW  = WIDTH * WORDS;
    localparam int DW    = LANES * ROWW;

    logic clk;
    logic rst;

    buffer_ram_mp_if #(.DEPTHAD(4), .LANES(LANES), .WIDTH(WIDTH), .WORDS(WORDS)) bus_a ();
    buffer_ram_mp_if #(.DEPTHAD(3), .LANES(LANES), .WIDTH(WIDTH), .WORDS(WORDS)) bus_b ();

    buffer_ram_mp #(.ID(0), .DEPTH(12), .WIDTH(WIDTH), .WORDS(WORDS), .LANES(LANES),
                    .READ_LATENCY(1), .RDW_MODE(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    buffer_ram_mp #(.ID(1), .DEPTH(6), .WIDTH(WIDTH), .WORDS(WORDS), .LANES(LANES),
                    .READ_LATENCY(3), .RDW_MODE(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t            sb0[$];
    exp_t            sb1[$];
    logic [ROWW-1:0] model [2][12];
    logic [DW-1:0]   last_q [2];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc   = 0;

    logic        s_rst, s_rden;
    int          s_raddr, s_waddr;
    logic [1:0]  s_wren;
    logic [DW-1:0] s_wdata;
    logic [7:0]  s_wmask;

    function automatic int dep(input int d);
        return (d == 0) ? 12 : 6;
    endfunction
    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction
    function automatic int mode(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    task automatic set_idle();
        s_rst = 1'b0; s_rden = 1'b0; s_raddr = 0; s_waddr = 0;
        s_wren = 2'b00; s_wdata = '0; s_wmask = 8'h00;
    endtask

    task automatic check(input int d);
        logic          v;
        logic [DW-1:0] dat;
        exp_t          e;
        bit            have;
        v   = (d == 0) ? bus_a.rvalid : bus_b.rvalid;
        dat = (d == 0) ? bus_a.rdata  : bus_b.rdata;
        if (rst) begin
            n_cmp++;
            assert ({v, dat} === {1'b0, {DW{1'b0}}})
                else begin
                    n_bad++;
                    $error("FAIL reset_out dut%0d: rvalid=%0b rdata=%h required rvalid=0 rdata=0", d, v, dat);
                end
            last_q[d] = '0;
        end else begin
            if (d == 0) have = (sb0.size() > 0) && (sb0[0].due == cyc);
            else        have = (sb1.size() > 0) && (sb1[0].due == cyc);
            if (have) begin
                if (d == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                n_cmp++;
                assert ({v, dat} === {1'b1, e.data})
                    else begin
                        n_bad++;
                        $error("FAIL read_beat dut%0d cyc %0d: rvalid=%0b rdata=%h required rvalid=1 rdata=%h",
                               d, cyc, v, dat, e.data);
                    end
                $display("read dut%0d cyc %0d rdata=%h", d, cyc, dat);
                last_q[d] = e.data;
            end else begin
                n_cmp++;
                assert ({v, dat} === {1'b0, last_q[d]})
                    else begin
                        n_bad++;
                        $error("FAIL idle_hold dut%0d cyc %0d: rvalid=%0b rdata=%h required rvalid=0 rdata=%h",
                               d, cyc, v, dat, last_q[d]);
                    end
            end
        end
    endtask

    // Drive the current stimulus for one clock, update the models, check.
    task automatic cycle();
        logic [DW-1:0]   exp;
        logic [ROWW-1:0] row;
        exp_t            e;
        int              r, w;
        rst         = s_rst;
        bus_a.rden  = s_rden;           bus_b.rden  = s_rden;
        bus_a.raddr = 4'(s_raddr % 12); bus_b.raddr = 3'(s_raddr % 6);
        bus_a.wren  = s_wren;           bus_b.wren  = s_wren;
        bus_a.waddr = 4'(s_waddr % 12); bus_b.waddr = 3'(s_waddr % 6);
        bus_a.wdata = s_wdata;          bus_b.wdata = s_wdata;
        bus_a.wmask = s_wmask;          bus_b.wmask = s_wmask;
        for (int d = 0; d < 2; d++) begin
            if (s_rst) begin
                if (d == 0) sb0.delete();
                else        sb1.delete();
            end else begin
                exp = '0;
                if (s_rden) begin
                    for (int a = 0; a < LANES; a++) begin
                        r   = ((s_raddr % dep(d)) + a) % dep(d);
                        row = model[d][r];
                        if (mode(d) == 1) begin
                            for (int b = 0; b < LANES; b++) begin
                                w = ((s_waddr % dep(d)) + b) % dep(d);
                                if (s_wren[b] && (w == r))
                                    for (int j = 0; j < WORDS; j++)
                                        if (s_wmask[b*WORDS + j])
                                            row[j*WIDTH +: WIDTH] = s_wdata[b*ROWW + j*WIDTH +: WIDTH];
                            end
                        end
                        exp[a*ROWW +: ROWW] = row;
                    end
                    e.due  = cyc + 1 + lat(d);
                    e.data = exp;
                    if (d == 0) sb0.push_back(e);
                    else        sb1.push_back(e);
                end
                for (int b = 0; b < LANES; b++) begin
                    w = ((s_waddr % dep(d)) + b) % dep(d);
                    if (s_wren[b])
                        for (int j = 0; j < WORDS; j++)
                            if (s_wmask[b*WORDS + j])
                                model[d][w][j*WIDTH +: WIDTH] = s_wdata[b*ROWW + j*WIDTH +: WIDTH];
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check(0);
        check(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            cycle();
        end
    endtask

    initial begin
        // Reset
        set_idle();
        s_rst = 1'b1;
        cycle();
        cycle();

        // Rows 0..11 written with their own index in every word
        for (int i = 0; i < 6; i++) begin
            set_idle();
            s_wren  = 2'b11;
            s_waddr = 2 * i;
            s_wdata = {{WORDS{8'(2*i + 1)}}, {WORDS{8'(2*i)}}};
            s_wmask = 8'hFF;
            cycle();
        end

        // Back-to-back reads, bases 0,2,4,6
        for (int i = 0; i < 4; i++) begin
            set_idle();
            s_rden  = 1'b1;
            s_raddr = 2 * i;
            cycle();
        end
        idle(5);

        // Wrap: write base 5 {A,B}, read base 5, then row 1
        set_idle();
        s_wren  = 2'b11; s_waddr = 5;
        s_wdata = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        s_wmask = 8'hFF;
        cycle();
        set_idle(); s_rden = 1'b1; s_raddr = 5; cycle();
        set_idle(); s_rden = 1'b1; s_raddr = 1; cycle();
        idle(5);

        // Mask: row 3 all 0xFF, then lane 0 writes 0 into even words only
        set_idle();
        s_wren = 2'b01; s_waddr = 3; s_wdata = {DW{1'b1}}; s_wmask = 8'hFF;
        cycle();
        set_idle();
        s_wren = 2'b01; s_waddr = 3; s_wdata = '0; s_wmask = 8'b0000_0101;
        cycle();
        set_idle(); s_rden = 1'b1; s_raddr = 3; cycle();
        idle(5);

        // Read-during-write on row 4: X then Y written while reading
        set_idle();
        s_wren = 2'b01; s_waddr = 4; s_wdata = {32'h0, 32'h1122_3344}; s_wmask = 8'h0F;
        cycle();
        set_idle();
        s_wren = 2'b01; s_waddr = 4; s_wdata = {32'h0, 32'h5566_7788}; s_wmask = 8'h0F;
        s_rden = 1'b1;  s_raddr = 4;
        cycle();
        set_idle(); s_rden = 1'b1; s_raddr = 4; cycle();
        idle(5);

        // Cross-lane read-during-write: read lane 1 hits write lane 0
        set_idle();
        s_wren = 2'b11; s_waddr = 2; s_wdata = {32'hCAFE_F00D, 32'hDEAD_BEEF}; s_wmask = 8'hFF;
        s_rden = 1'b1;  s_raddr = 1;
        cycle();
        idle(5);

        // Reset mid-flight: three reads, then one reset cycle
        for (int i = 0; i < 3; i++) begin
            set_idle();
            s_rden  = 1'b1;
            s_raddr = 2 * i;
            cycle();
        end
        set_idle(); s_rst = 1'b1; s_rden = 1'b1; s_wren = 2'b11; s_wdata = '1; s_wmask = 8'hFF;
        cycle();
        idle(5);
        set_idle(); s_rden = 1'b1; s_raddr = 0; cycle();
        idle(5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_idle();
            s_rst   = ($urandom_range(0, 49) == 0);
            s_rden  = 1'($urandom_range(0, 1));
            s_raddr = $urandom_range(0, 11);
            s_wren  = 2'($urandom_range(0, 3));
            s_waddr = $urandom_range(0, 11);
            s_wdata = {$urandom, $urandom};
            s_wmask = 8'($urandom_range(0, 255));
            cycle();
        end
        idle(6);

        // Every scheduled response must have been delivered
        n_cmp++;
        assert (sb0.size() === 0)
            else begin n_bad++; $error("FAIL drain dut0: %0d beats pending, required 0", sb0.size()); end
        n_cmp++;
        assert (sb1.size() === 0)
            else begin n_bad++; $error("FAIL drain dut1: %0d beats pending, required 0", sb1.size()); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
